// File: rtl/ex_flag_stage_if.sv
// EX -> EX/MEM boundary bundle for ex_flag_stage; the master drives EX-side inputs and control.
// Define EX_FLAG_OV_STICKY_EN to add the clr_sticky / ov_sticky / ov_count signals.
interface ex_flag_stage_if #(
  parameter int DW = 16,
  parameter int RW = 4
);
  logic          in_valid;
  logic [3:0]    in_alu_op;
  logic          in_is_alu;
  logic          in_is_br;
  logic [2:0]    in_cc;
  logic [DW-1:0] in_dst;
  logic          in_ov;
  logic          in_zr;
  logic          in_wr_en;
  logic [RW-1:0] in_wr_reg;
  logic          stall;
  logic          flush;

  logic          out_valid;
  logic [DW-1:0] out_result;
  logic          out_wr_en;
  logic [RW-1:0] out_wr_reg;
  logic          br_taken;
  logic          flag_z;
  logic          flag_v;
  logic          flag_n;
`ifdef EX_FLAG_OV_STICKY_EN
  logic          clr_sticky;
  logic          ov_sticky;
  logic [7:0]    ov_count;
`endif

  modport master (
    output in_valid, in_alu_op, in_is_alu, in_is_br, in_cc, in_dst, in_ov, in_zr,
           in_wr_en, in_wr_reg, stall, flush,
    input  out_valid, out_result, out_wr_en, out_wr_reg, br_taken, flag_z, flag_v, flag_n
`ifdef EX_FLAG_OV_STICKY_EN
    , output clr_sticky
    , input  ov_sticky, ov_count
`endif
  );

  modport slave (
    input  in_valid, in_alu_op, in_is_alu, in_is_br, in_cc, in_dst, in_ov, in_zr,
           in_wr_en, in_wr_reg, stall, flush,
    output out_valid, out_result, out_wr_en, out_wr_reg, br_taken, flag_z, flag_v, flag_n
`ifdef EX_FLAG_OV_STICKY_EN
    , input  clr_sticky
    , output ov_sticky, ov_count
`endif
  );
endinterface

// File: rtl/ex_flag_stage.sv
// EX/MEM pipeline register plus Z/V/N flag register and conditional-branch resolution.
// Optional overflow sticky bit and saturating counter enabled by defining EX_FLAG_OV_STICKY_EN.
`ifndef ALU_ADD
`define ALU_ADD 4'b0000
`endif
`ifndef ALU_SUB
`define ALU_SUB 4'b0001
`endif
`ifndef ALU_AND
`define ALU_AND 4'b0010
`endif
`ifndef ALU_NOR
`define ALU_NOR 4'b0011
`endif

module ex_flag_stage #(
  parameter int DW = 16,
  parameter int RW = 4
) (
  input logic           clk,
  input logic           rst_n,
  ex_flag_stage_if.slave bus
);
  logic          valid_reg;
  logic [DW-1:0] result_reg;
  logic          wr_en_reg;
  logic [RW-1:0] wr_reg_reg;
  logic          br_taken_reg;
  logic          z_reg;
  logic          v_reg;
  logic          n_reg;

  logic cap;
  logic is_arith;
  logic is_logic;
  logic cond;

  assign cap      = bus.in_valid & ~bus.stall & ~bus.flush;
  assign is_arith = (bus.in_alu_op == `ALU_ADD) || (bus.in_alu_op == `ALU_SUB);
  assign is_logic = (bus.in_alu_op == `ALU_AND) || (bus.in_alu_op == `ALU_NOR);

  // Condition is evaluated against the registered flags, i.e. before this edge's update.
  always_comb begin
    cond = 1'b0;
    case (bus.in_cc)
      3'b000: cond = ~z_reg;
      3'b001: cond = z_reg;
      3'b010: cond = ~z_reg & ~n_reg;
      3'b011: cond = n_reg;
      3'b100: cond = z_reg | (~z_reg & ~n_reg);
      3'b101: cond = n_reg | z_reg;
      3'b110: cond = v_reg;
      default: cond = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg    <= 1'b0;
      result_reg   <= '0;
      wr_en_reg    <= 1'b0;
      wr_reg_reg   <= '0;
      br_taken_reg <= 1'b0;
      z_reg        <= 1'b0;
      v_reg        <= 1'b0;
      n_reg        <= 1'b0;
    end else if (bus.flush) begin
      valid_reg    <= 1'b0;
      wr_en_reg    <= 1'b0;
      br_taken_reg <= 1'b0;
    end else if (bus.stall) begin
      // Everything holds; only the branch pulse drops so it fires once.
      br_taken_reg <= 1'b0;
    end else begin
      valid_reg    <= bus.in_valid;
      wr_en_reg    <= bus.in_valid & bus.in_wr_en;
      br_taken_reg <= bus.in_valid & bus.in_is_br & cond;
      if (bus.in_valid) begin
        result_reg <= bus.in_dst;
        wr_reg_reg <= bus.in_wr_reg;
      end
      if (cap && bus.in_is_alu && is_arith) begin
        z_reg <= bus.in_zr;
        v_reg <= bus.in_ov;
        n_reg <= bus.in_dst[DW-1];
      end else if (cap && bus.in_is_alu && is_logic) begin
        z_reg <= bus.in_zr;
      end
    end
  end

  assign bus.out_valid  = valid_reg;
  assign bus.out_result = result_reg;
  assign bus.out_wr_en  = wr_en_reg;
  assign bus.out_wr_reg = wr_reg_reg;
  assign bus.br_taken   = br_taken_reg;
  assign bus.flag_z     = z_reg;
  assign bus.flag_v     = v_reg;
  assign bus.flag_n     = n_reg;

`ifdef EX_FLAG_OV_STICKY_EN
  logic       ov_sticky_reg;
  logic [7:0] ov_count_reg;
  logic       ov_event;

  assign ov_event = cap & bus.in_is_alu & is_arith & bus.in_ov;

  // A set event on the same edge as a clear restarts the count at one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ov_sticky_reg <= 1'b0;
      ov_count_reg  <= 8'h00;
    end else if (!bus.stall && !bus.flush) begin
      if (ov_event) begin
        ov_sticky_reg <= 1'b1;
        if (bus.clr_sticky)
          ov_count_reg <= 8'h01;
        else if (ov_count_reg != 8'hFF)
          ov_count_reg <= ov_count_reg + 8'h01;
      end else if (bus.clr_sticky) begin
        ov_sticky_reg <= 1'b0;
        ov_count_reg  <= 8'h00;
      end
    end
  end

  assign bus.ov_sticky = ov_sticky_reg;
  assign bus.ov_count  = ov_count_reg;
`endif
endmodule

// File: doc/ex_flag_stage.md
Name: ex_flag_stage

Overview:
- Execute-to-memory boundary stage that sits directly downstream of the 16-bit saturating ALU.
- Captures the ALU result and its ov/zr outputs into the EX/MEM pipeline register.
- Maintains the architectural flag register (Z, V, N) and resolves conditional branches against it.
- Supports pipeline stall and flush, so the ALU stays purely combinational.

Parameters:
- DW, 16, datapath width; must match the ALU result width.
- RW, 4, destination register index width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  the EX stage holds a real instruction this cycle.
- in_alu_op  input  4  ALU opcode, encoded with the ALU_* defines from defines.v.
- in_is_alu  input  1  the instruction is an ALU op and is eligible to update flags.
- in_is_br  input  1  the instruction is a conditional branch.
- in_cc  input  3  branch condition code.
- in_dst  input  DW  ALU result (dst).
- in_ov  input  1  ALU ov output.
- in_zr  input  1  ALU zr output.
- in_wr_en  input  1  register-file write enable, passed through.
- in_wr_reg  input  RW  destination register index, passed through.
- stall  input  1  hold every register in this stage.
- flush  input  1  squash the instruction being captured.
- out_valid  output  1  EX/MEM valid.
- out_result  output  DW  registered ALU result.
- out_wr_en  output  1  registered write enable, gated by valid.
- out_wr_reg  output  RW  registered destination register index.
- br_taken  output  1  registered branch-taken pulse.
- flag_z, flag_v, flag_n  output  1 each  architectural flags.

Behaviour:
- Reset (async, rst_n=0): all outputs and internal registers are 0, including every flag. Rising edges are ignored while rst_n=0. Reset may assert mid-operation and clears everything immediately.
- Latency: one cycle. Inputs presented in cycle N appear on the outputs after the rising edge that ends cycle N.
- Capture condition: cap = in_valid & ~stall & ~flush.
- Precedence on each edge: flush > stall > capture.
- Flush: out_valid=0, out_wr_en=0, br_taken=0. Flags are not updated. out_result and out_wr_reg may hold don't-care values.
- Stall (without flush): all registers hold, including flags. br_taken is forced to 0 so a taken branch pulses only once.
- Idle (in_valid=0, no stall/flush): out_valid=0, out_wr_en=0, br_taken=0. Flags hold.
- Normal capture: out_valid=1, out_result=in_dst, out_wr_en=in_wr_en, out_wr_reg=in_wr_reg.
- Flag update, only when cap & in_is_alu:
  - ALU_ADD / ALU_SUB: Z<=in_zr, V<=in_ov, N<=in_dst[DW-1]. These are post-saturation values.
  - ALU_AND / ALU_NOR: Z<=in_zr only; V and N hold.
  - Shifts and ALU_LHB: no flag change.
- Branch resolution when cap & in_is_br: br_taken<=cond(in_cc), evaluated against the current registered flags, before this edge's update.
- Branch conditions by in_cc:
  - 000 NE: ~Z
  - 001 EQ: Z
  - 010 GT: ~Z&~N
  - 011 LT: N
  - 100 GE: Z | (~Z&~N)
  - 101 LE: N | Z
  - 110 OV: V
  - 111 UN: 1
- Simultaneous in_is_alu and in_is_br: the branch uses the old flags; the flags then update.
- Back-to-back: a branch in cycle N+1 sees flags written by an ALU op captured in cycle N. No bypass is needed.

Optional Feature:
- Macro: EX_FLAG_OV_STICKY_EN.
- When defined:
  - Adds input clr_sticky (1 bit).
  - Adds output ov_sticky (1 bit): set on any edge where an ADD/SUB is captured with in_ov=1.
  - Adds output ov_count (8 bits): counts those events and saturates at 8'hFF without wrapping.
  - clr_sticky=1 clears both outputs on the next edge. If a set event occurs on the same edge, the set event wins: sticky=1, count=1.
  - Both outputs reset to 0 and hold during stall and flush.
- When not defined: neither port exists and there is no related logic.

Test Plan:
- Reset mid-stream: assert rst_n=0 with out_valid=1 and Z=1 -> all outputs 0 immediately, before any clock edge.
- ADD with in_dst=16'h7FFF, in_ov=1, in_zr=0 -> next cycle out_result=7FFF, V=1, N=0, Z=0. Follow with AND, in_zr=1 -> Z=1, V stays 1.
- Flags Z=0, N=1; branch in_cc=011 in the same cycle as an ADD with in_zr=1 -> br_taken=1 (old flags used), then Z=1, N set from in_dst[15].
- Taken branch (cc=111) held under stall for 3 cycles -> br_taken is 1 for exactly one cycle, then 0 while stalled.
- in_valid=1, in_wr_en=1, stall=1, flush=1 -> out_valid=0, out_wr_en=0, flags unchanged.
- EX_FLAG_OV_STICKY_EN: 256 overflowing ADDs -> ov_count=FF and holds. Then clr_sticky coincident with an overflowing SUB -> ov_sticky=1, ov_count=1.
